maj_sweep_checker: RTL and testbench

- Synthesizable stimulus-and-check stage that sits directly around the N-input majority netlist (`top`, ports x0..x(N-1), y0).
- Drives the majority input vector each cycle and consumes y0, either from an exhaustive counter or from an LFSR.
- Compares y0 against an internal popcount reference, `popcount(x) >= (N+1)/2`, after a configurable DUT latency.
- Reports a pass/fail summary, so mapped and folded majority netlists can be checked on FPGA/emulation instead of only by a 2^31-cycle simulation.

---
 rtl/maj_sweep_checker_if.sv | 29 ++
 rtl/maj_sweep_checker.sv | 178 +++++++++++++++++
 tb/tb_maj_sweep_checker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/maj_sweep_checker_if.sv
// Stimulus/check bundle between maj_sweep_checker (slave) and its controller plus the majority netlist (master).
// Carries the sweep control, the x/y path to the DUT and the result registers.
interface maj_sweep_checker_if #(
    parameter int N    = 31,
    parameter int ERRW = 16
);
    logic            start;
    logic            mode;
    logic [31:0]     num_vec;
    logic [N-1:0]    x_out;
    logic            y_dut;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_count;
    logic [N-1:0]    first_err_vec;
    logic            first_err_valid;
    logic [31:0]     vec_count;

    modport master (
        output start, mode, num_vec, y_dut,
        input  x_out, busy, done, pass, err_count, first_err_vec, first_err_valid, vec_count
    );

    modport slave (
        input  start, mode, num_vec, y_dut,
        output x_out, busy, done, pass, err_count, first_err_vec, first_err_valid, vec_count
    );
endinterface

// File: rtl/maj_sweep_checker.sv
// Sweeps an N-input majority netlist (exhaustive or LFSR) and checks y0 against a popcount reference after LAT clocks.
// One vector per clock, no backpressure; start is ignored while a sweep is in flight.
module maj_sweep_checker #(
    parameter int             N    = 31,
    parameter int             LAT  = 0,
    parameter int             ERRW = 16,
    parameter logic [N-1:0]   SEED = N'(1),
    parameter logic [N-1:0]   TAPS = N'(31'h48000000)
) (
    input  logic                clk,
    input  logic                rst,
    maj_sweep_checker_if.slave  sw
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [31:0]     issue_q, issue_d;
    logic [2:0]      drain_q, drain_d;
    logic            mode_q, mode_d;
    logic [31:0]     nvec_q, nvec_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [N-1:0]    fev_q, fev_d;
    logic            fevv_q, fevv_d;
    logic [31:0]     vcnt_q, vcnt_d;

    logic            run;
    logic            ref_cur;
    logic            dly_vld;
    logic [N-1:0]    dly_x;
    logic            dly_ref;
    logic            mismatch;
    logic [N-1:0]    lfsr_next;
    logic [31:0]     last_vec;

    function automatic logic [4:0] popcnt(input logic [N-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    assign run       = (state_q == RUN);
    assign ref_cur   = (popcnt(x_q) >= 5'((N + 1) / 2));
    assign lfsr_next = x_q[0] ? ((x_q >> 1) ^ TAPS) : (x_q >> 1);
    assign last_vec  = mode_q ? nvec_q : (32'd1 << N);

    // Delay line aligns the reference with the DUT's pipelined y0.
    if (LAT == 0) begin : g_nodly
        assign dly_vld = run;
        assign dly_x   = x_q;
        assign dly_ref = ref_cur;
    end else begin : g_dly
        logic [LAT-1:0]        vld_q;
        logic [LAT-1:0][N-1:0] xs_q;
        logic [LAT-1:0]        ref_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                xs_q  <= '0;
                ref_q <= '0;
            end else begin
                vld_q[0] <= run;
                xs_q[0]  <= x_q;
                ref_q[0] <= ref_cur;
                for (int i = 1; i < LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    xs_q[i]  <= xs_q[i-1];
                    ref_q[i] <= ref_q[i-1];
                end
            end
        end

        assign dly_vld = vld_q[LAT-1];
        assign dly_x   = xs_q[LAT-1];
        assign dly_ref = ref_q[LAT-1];
    end

    // Case equality makes an X on y0 land in the mismatch branch in simulation.
    always_comb begin
        case (sw.y_dut ^ dly_ref)
            1'b0:    mismatch = 1'b0;
            default: mismatch = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        issue_d = issue_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        nvec_d  = nvec_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        vcnt_d  = vcnt_q;

        if (dly_vld) begin
            vcnt_d = vcnt_q + 32'd1;
            if (mismatch) begin
                if (err_q != '1) err_d = err_q + ERRW'(1);
                if (!fevv_q) begin
                    fevv_d = 1'b1;
                    fev_d  = dly_x;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (sw.start) begin
                    state_d = RUN;
                    x_d     = sw.mode ? SEED : '0;
                    mode_d  = sw.mode;
                    nvec_d  = (sw.num_vec == 32'd0) ? 32'd1 : sw.num_vec;
                    issue_d = 32'd1;
                    err_d   = '0;
                    fev_d   = '0;
                    fevv_d  = 1'b0;
                    vcnt_d  = '0;
                end
            end
            RUN: begin
                if (issue_q == last_vec) begin
                    state_d = (LAT == 0) ? DONE : DRAIN;
                    drain_d = 3'd1;
                end else begin
                    issue_d = issue_q + 32'd1;
                    x_d     = mode_q ? lfsr_next : x_q + N'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 3'(LAT)) state_d = DONE;
                else                    drain_d = drain_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            issue_q <= '0;
            drain_q <= '0;
            mode_q  <= 1'b0;
            nvec_q  <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            issue_q <= issue_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
            nvec_q  <= nvec_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign sw.x_out           = x_q;
    assign sw.busy            = (state_q == RUN) || (state_q == DRAIN);
    assign sw.done            = (state_q == DONE);
    assign sw.pass            = (state_q == DONE) && (err_q == '0);
    assign sw.err_count       = err_q;
    assign sw.first_err_vec   = fev_q;
    assign sw.first_err_valid = fevv_q;
    assign sw.vec_count       = vcnt_q;

endmodule

// File: tb/tb_maj_sweep_checker.sv
// Scoreboard bench: four checker instances around behavioural majority models with injectable faults.
module tb_maj_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int t;
    int fm_a = 0, fm_b = 0, fm_c = 0;

    typedef struct {
        int cyc;
        int err;
        int fev;
        bit fevv;
        bit pas;
        int vcnt;
    } exp_t;

    exp_t        qa[$], qb[$], qc[$], qd[$];
    logic [30:0] qdx[$];

    function automatic exp_t mk(input int c, input int e, input int f, input bit fv, input bit p, input int v);
        exp_t r;
        r.cyc = c; r.err = e; r.fev = f; r.fevv = fv; r.pas = p; r.vcnt = v;
        return r;
    endfunction

    function automatic logic maj5(input logic [4:0] x);
        return ($countones(x) >= 3);
    endfunction

    function automatic logic maj31(input logic [30:0] x);
        return ($countones(x) >= 16);
    endfunction

    // 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
    function automatic logic flt(input int fm, input logic m);
        case (fm)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !m;
            default: return m;
        endcase
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk(input string nm, input exp_t e, input int c, input int err, input int fev,
                       input bit fv, input bit ps, input int vc);
        cmp({nm, ".done_cycle"}, c, e.cyc);
        cmp({nm, ".err_count"}, err, e.err);
        cmp({nm, ".first_err_vec"}, fev, e.fev);
        cmp({nm, ".first_err_valid"}, fv, e.fevv);
        cmp({nm, ".pass"}, ps, e.pas);
        cmp({nm, ".vec_count"}, vc, e.vcnt);
    endtask

    maj_sweep_checker_if #(.N(5),  .ERRW(3))  a_if ();
    maj_sweep_checker_if #(.N(5),  .ERRW(16)) b_if ();
    maj_sweep_checker_if #(.N(5),  .ERRW(16)) c_if ();
    maj_sweep_checker_if #(.N(31), .ERRW(16)) d_if ();

    maj_sweep_checker #(.N(5),  .LAT(0), .ERRW(3))  u_a (.clk(clk), .rst(rst_a), .sw(a_if.slave));
    maj_sweep_checker #(.N(5),  .LAT(3), .ERRW(16)) u_b (.clk(clk), .rst(rst_b), .sw(b_if.slave));
    maj_sweep_checker #(.N(5),  .LAT(2), .ERRW(16)) u_c (.clk(clk), .rst(rst_c), .sw(c_if.slave));
    maj_sweep_checker #(.N(31), .LAT(1), .ERRW(16)) u_d (.clk(clk), .rst(rst_d), .sw(d_if.slave));

    // Majority netlist models: combinational for A, registered LAT deep for the others.
    logic [2:0] b_p = '0;
    logic [1:0] c_p = '0;
    logic       d_p = 1'b0;
    assign a_if.y_dut = flt(fm_a, maj5(a_if.x_out));
    always @(posedge clk) b_p <= {b_p[1:0], flt(fm_b, maj5(b_if.x_out))};
    always @(posedge clk) c_p <= {c_p[0], flt(fm_c, maj5(c_if.x_out))};
    always @(posedge clk) d_p <= maj31(d_if.x_out);
    assign b_if.y_dut = b_p[2];
    assign c_if.y_dut = c_p[1];
    assign d_if.y_dut = d_p;

    // Monitor: pops an expectation on every rising done, and the LFSR sequence each RUN cycle of D.
    logic a_dn = 1'b0, b_dn = 1'b0, c_dn = 1'b0, d_dn = 1'b0;
    always @(negedge clk) begin
        if (a_if.done && !a_dn) begin
            if (qa.size() == 0) cmp("A.unexpected_done", 1, 0);
            else chk("A", qa.pop_front(), cyc, int'(a_if.err_count), int'(a_if.first_err_vec),
                     a_if.first_err_valid, a_if.pass, int'(a_if.vec_count));
        end
        if (b_if.done && !b_dn) begin
            if (qb.size() == 0) cmp("B.unexpected_done", 1, 0);
            else chk("B", qb.pop_front(), cyc, int'(b_if.err_count), int'(b_if.first_err_vec),
                     b_if.first_err_valid, b_if.pass, int'(b_if.vec_count));
        end
        if (c_if.done && !c_dn) begin
            if (qc.size() == 0) cmp("C.unexpected_done", 1, 0);
            else chk("C", qc.pop_front(), cyc, int'(c_if.err_count), int'(c_if.first_err_vec),
                     c_if.first_err_valid, c_if.pass, int'(c_if.vec_count));
        end
        if (d_if.done && !d_dn) begin
            if (qd.size() == 0) cmp("D.unexpected_done", 1, 0);
            else chk("D", qd.pop_front(), cyc, int'(d_if.err_count), int'(d_if.first_err_vec),
                     d_if.first_err_valid, d_if.pass, int'(d_if.vec_count));
        end
        if (d_if.busy && qdx.size() != 0) cmp("D.lfsr_x_out", longint'(d_if.x_out), longint'(qdx.pop_front()));
        a_dn <= a_if.done;
        b_dn <= b_if.done;
        c_dn <= c_if.done;
        d_dn <= d_if.done;
    end

    task automatic wait_all(input int budget);
        int n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size() + qdx.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        cmp("scoreboard_drained_in_time", (n < budget) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [30:0] s;
        a_if.start = 0; a_if.mode = 0; a_if.num_vec = 0;
        b_if.start = 0; b_if.mode = 0; b_if.num_vec = 0;
        c_if.start = 0; c_if.mode = 0; c_if.num_vec = 0;
        d_if.start = 0; d_if.mode = 0; d_if.num_vec = 0;
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;

        cmp("A.rst.x_out", a_if.x_out, 0);
        cmp("A.rst.busy", a_if.busy, 0);
        cmp("A.rst.done", a_if.done, 0);
        cmp("A.rst.pass", a_if.pass, 0);
        cmp("A.rst.err_count", a_if.err_count, 0);
        cmp("A.rst.first_err_valid", a_if.first_err_valid, 0);
        cmp("A.rst.vec_count", a_if.vec_count, 0);
        cmp("D.rst.x_out", d_if.x_out, 0);
        cmp("D.rst.busy", d_if.busy, 0);

        // A: ideal exhaustive sweep, 32 compares, done 32 cycles after start
        fm_a = 0; a_if.start = 1; t = cyc + 1;
        qa.push_back(mk(t + 32, 0, 0, 0, 1, 32));
        @(negedge clk); a_if.start = 0;
        wait_all(100);

        // A: stuck-at-1, 16 mismatches saturate a 3-bit counter at 7; restart from DONE
        fm_a = 2; a_if.start = 1; t = cyc + 1;
        qa.push_back(mk(t + 32, 7, 0, 1, 0, 32));
        @(negedge clk); a_if.start = 0;
        wait_all(100);

        // C: LAT=2, stuck-at-0 fails the 16 vectors with >=3 ones, first is 5'b00111
        fm_c = 1; c_if.start = 1; t = cyc + 1;
        qc.push_back(mk(t + 34, 16, 7, 1, 0, 32));
        @(negedge clk); c_if.start = 0;
        wait_all(100);

        // B: LAT=3, inverted model fails everything; then restart with an ideal model
        fm_b = 3; b_if.start = 1; t = cyc + 1;
        qb.push_back(mk(t + 35, 32, 0, 1, 0, 32));
        @(negedge clk); b_if.start = 0;
        wait_all(100);
        fm_b = 0; b_if.start = 1; t = cyc + 1;
        qb.push_back(mk(t + 35, 0, 0, 0, 1, 32));
        @(negedge clk); b_if.start = 0;
        cmp("B.restart.err_count", b_if.err_count, 0);
        cmp("B.restart.first_err_valid", b_if.first_err_valid, 0);
        cmp("B.restart.done", b_if.done, 0);
        wait_all(100);

        // D: N=31 LFSR, 1000 vectors; mode/num_vec changed mid-run must not matter
        s = 31'h1;
        for (int i = 0; i < 1000; i++) begin
            qdx.push_back(s);
            s = s[0] ? ((s >> 1) ^ 31'h48000000) : (s >> 1);
        end
        d_if.mode = 1; d_if.num_vec = 1000; d_if.start = 1; t = cyc + 1;
        qd.push_back(mk(t + 1001, 0, 0, 0, 1, 1000));
        @(negedge clk); d_if.start = 0; d_if.mode = 0; d_if.num_vec = 5;
        wait_all(1200);

        // D: num_vec=0 behaves as a single vector
        qdx.push_back(31'h1);
        d_if.mode = 1; d_if.num_vec = 0; d_if.start = 1; t = cyc + 1;
        qd.push_back(mk(t + 2, 0, 0, 0, 1, 1));
        @(negedge clk); d_if.start = 0;
        wait_all(100);

        // A: reset at vector 10 aborts the sweep with no done
        fm_a = 0; a_if.start = 1;
        @(negedge clk); a_if.start = 0;
        repeat (10) @(negedge clk);
        cmp("A.midrun.vec_count", a_if.vec_count, 10);
        rst_a = 1;
        @(negedge clk); rst_a = 0;
        cmp("A.midrst.x_out", a_if.x_out, 0);
        cmp("A.midrst.busy", a_if.busy, 0);
        cmp("A.midrst.done", a_if.done, 0);
        cmp("A.midrst.vec_count", a_if.vec_count, 0);
        cmp("A.midrst.first_err_vec", a_if.first_err_vec, 0);
        repeat (40) @(negedge clk);
        cmp("A.midrst.still_idle", {a_if.busy, a_if.done}, 0);

        // A: a second start while busy is ignored, length stays 32
        a_if.start = 1; t = cyc + 1;
        qa.push_back(mk(t + 32, 0, 0, 0, 1, 32));
        @(negedge clk); a_if.start = 0;
        repeat (4) @(negedge clk);
        a_if.start = 1;
        @(negedge clk); a_if.start = 0;
        wait_all(100);

        cmp("scoreboard_empty", qa.size() + qb.size() + qc.size() + qd.size() + qdx.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
